// File: rtl/srisc_queued_core.sv
// ============================================================================
// Module   : srisc_queued_core
// Purpose  : Queued Simple-RISC core with a parametrised DATA_W datapath.
//            The host preloads up to IQ_DEPTH 16-bit instructions, then
//            pulses s. The core drains the queue through an eight-entry
//            register file. Supported instructions are MOV imm, MOV reg,
//            ADD, CMP, AND and MVN, each with an optional shift of Rm.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1       rising-edge clock
//   reset_n  in   1       asynchronous active-low reset; also flushes the queue
//   load_i   in   1       push in_i into the queue when it is not full
//   in_i     in   16      instruction word
//   s_i      in   1       start pulse; honoured only while idle with work queued
//   out_o    out  DATA_W  last value written to a register
//   n_o      out  1       negative flag (CMP only)
//   v_o      out  1       signed-overflow flag (CMP only)
//   z_o      out  1       zero flag (CMP only)
//   w_o      out  1       1 = idle / waiting, 0 = running
//   full_o   out  1       queue holds IQ_DEPTH entries
//   empty_o  out  1       queue holds no entries
//   ill_o    out  1       sticky: an illegal instruction was consumed
// ----------------------------------------------------------------------------
// Configuration macro
//   SRISC_STEP_EN  When defined, each accepted start executes exactly one
//                  queued instruction and then returns to idle.
// ============================================================================
`default_nettype none

module srisc_queued_core #(
  parameter int DATA_W   = 16,
  parameter int IQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [15:0]       in_i,
  input  logic              s_i,
  output logic [DATA_W-1:0] out_o,
  output logic              n_o,
  output logic              v_o,
  output logic              z_o,
  output logic              w_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ill_o
);

  localparam int            AW      = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(IQ_DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_EXEC  = 3'd4,
    S_WR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_MOVI = 3'd0,
    C_MOVR = 3'd1,
    C_ADD  = 3'd2,
    C_CMP  = 3'd3,
    C_AND  = 3'd4,
    C_MVN  = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic cls_t decode(input logic [15:0] iw);
    cls_t c;
    c = C_ILL;
    if (iw[15:13] == 3'b110) begin
      if (iw[12:11] == 2'b10)      c = C_MOVI;
      else if (iw[12:11] == 2'b00) c = C_MOVR;
    end else if (iw[15:13] == 3'b101) begin
      case (iw[12:11])
        2'b00:   c = C_ADD;
        2'b01:   c = C_CMP;
        2'b10:   c = C_AND;
        default: c = C_MVN;
      endcase
    end
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] v,
                                                 input logic [1:0]        sh);
    logic [DATA_W-1:0] r;
    case (sh)
      2'b01:   r = {v[DATA_W-2:0], 1'b0};          // LSL #1
      2'b10:   r = {1'b0, v[DATA_W-1:1]};          // LSR #1
      2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};   // ASR #1
      default: r = v;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  logic [15:0]   iq_mem [IQ_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_head;
  cls_t          w_head_cls;

  state_t        state_q;
  state_t        state_d;

  assign full_o     = (cnt_q == C_DEPTH);
  assign empty_o    = (cnt_q == '0);
  assign w_push     = load_i && !full_o;
  // FETCH is only entered with a non-empty queue, so the pop is always valid.
  assign w_pop      = (state_q == S_FETCH);
  assign w_head     = iq_mem[rd_ptr_q];
  assign w_head_cls = decode(w_head);

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      iq_mem[wr_ptr_q] <= in_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Continue-or-stop decision at the end of an instruction.
  // An illegal instruction finishes in FETCH while its own entry is still
  // counted, so there it must look past the entry being popped.
  // --------------------------------------------------------------------------
  logic w_more_fetch;
  logic w_more;

`ifdef SRISC_STEP_EN
  assign w_more_fetch = 1'b0;
  assign w_more       = 1'b0;
`else
  assign w_more_fetch = (cnt_q > C_ONE);
  assign w_more       = !empty_o;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] rf_q [8];
  logic              n_q;
  logic              v_q;
  logic              z_q;
  logic              ill_q;

  cls_t              w_ir_cls;
  logic [DATA_W-1:0] w_shb;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_wr_val;
  logic [2:0]        w_wr_idx;
  logic              w_ovf;

  assign w_ir_cls = decode(ir_q);
  assign w_shb    = shift_op(b_q, ir_q[4:3]);
  assign w_diff   = a_q - w_shb;
  // Overflow on subtraction: operands differ in sign and the result sign
  // differs from the minuend.
  assign w_ovf    = (a_q[DATA_W-1] != w_shb[DATA_W-1]) &&
                    (w_diff[DATA_W-1] != a_q[DATA_W-1]);
  assign w_imm    = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    w_alu = w_shb;
    case (w_ir_cls)
      C_ADD:   w_alu = a_q + w_shb;
      C_AND:   w_alu = a_q & w_shb;
      C_MVN:   w_alu = ~w_shb;
      C_CMP:   w_alu = w_diff;
      default: w_alu = w_shb;
    endcase
  end

  // MOV imm overlays the immediate on the Rd field, so its target is Rn.
  assign w_wr_val = (w_ir_cls == C_MOVI) ? w_imm      : c_q;
  assign w_wr_idx = (w_ir_cls == C_MOVI) ? ir_q[10:8] : ir_q[7:5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      out_q <= '0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      ill_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q <= w_head;
          if (w_head_cls == C_ILL) ill_q <= 1'b1;
        end
        S_RD_A: a_q <= rf_q[ir_q[10:8]];
        S_RD_B: b_q <= rf_q[ir_q[2:0]];
        S_EXEC: begin
          c_q <= w_alu;
          if (w_ir_cls == C_CMP) begin
            z_q <= (w_diff == '0);
            n_q <= w_diff[DATA_W-1];
            v_q <= w_ovf;
          end
        end
        S_WR: begin
          rf_q[w_wr_idx] <= w_wr_val;
          out_q          <= w_wr_val;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (s_i && !empty_o) state_d = S_FETCH;
      end
      S_FETCH: begin
        case (w_head_cls)
          C_MOVI:              state_d = S_WR;
          C_MOVR, C_MVN:       state_d = S_RD_B;
          C_ADD, C_AND, C_CMP: state_d = S_RD_A;
          default:             state_d = w_more_fetch ? S_FETCH : S_IDLE;
        endcase
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: state_d = S_EXEC;
      S_EXEC: begin
        if (w_ir_cls == C_CMP) state_d = w_more ? S_FETCH : S_IDLE;
        else                   state_d = S_WR;
      end
      S_WR:    state_d = w_more ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_o   = (state_q == S_IDLE);
  assign out_o = out_q;
  assign n_o   = n_q;
  assign v_o   = v_q;
  assign z_o   = z_q;
  assign ill_o = ill_q;

endmodule

`default_nettype wire
